// File: rtl/sound_pkg.sv
// Shared types and note divider codes for the sound effect sequencer.
package sound_pkg;

  localparam int unsigned FREQ_W = 8;

  localparam logic [FREQ_W-1:0] NOTE_A4  = 8'd89;
  localparam logic [FREQ_W-1:0] NOTE_E5  = 8'd59;
  localparam logic [FREQ_W-1:0] NOTE_DS4 = 8'd126;
  localparam logic [FREQ_W-1:0] NOTE_G3  = 8'd199;
  localparam logic [FREQ_W-1:0] NOTE_C4  = 8'd149;
  localparam logic [FREQ_W-1:0] NOTE_OFF = 8'd0;

  // Encoding doubles as priority: larger value wins arbitration.
  typedef enum logic [1:0] {
    SFX_DIR  = 2'd0,
    SFX_GOOD = 2'd1,
    SFX_BAD  = 2'd2
  } sfx_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NOTE1 = 2'd1,
    NOTE2 = 2'd2
  } state_e;

  // Divider code sounding in a given state for a given effect.
  function automatic logic [FREQ_W-1:0] note_code(input state_e st, input sfx_e sfx);
    logic [FREQ_W-1:0] code;
    code = NOTE_OFF;
    case (st)
      NOTE1: begin
        case (sfx)
          SFX_BAD:  code = NOTE_DS4;
          SFX_GOOD: code = NOTE_A4;
          default:  code = NOTE_C4;
        endcase
      end
      NOTE2: begin
        case (sfx)
          SFX_BAD:  code = NOTE_G3;
          SFX_GOOD: code = NOTE_E5;
          default:  code = NOTE_OFF;
        endcase
      end
      default: code = NOTE_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Note duration down-counter; done is high while the count reads zero.
module note_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates game sound events by priority and plays timed one/two-note effects
// as registered tone-divider codes.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 1_000_000,
  parameter int unsigned BLIP_CYCLES = 250_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              goodColl_i,
  input  logic              badColl_i,
  input  logic [3:0]        direction_i,
  input  logic              mute_i,
  output logic [FREQ_W-1:0] freq,
  output logic              playing_o
);

  localparam int unsigned TIMER_W = $clog2(NOTE_CYCLES + 1);
  localparam logic [TIMER_W-1:0] NOTE_LOAD = TIMER_W'(NOTE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLIP_LOAD = TIMER_W'(BLIP_CYCLES - 1);

  state_e              state, state_n;
  sfx_e                sfx, sfx_n;
  logic [FREQ_W-1:0]   freq_n;
  logic                playing_n;
  logic                ev_valid_c;
  sfx_e                ev_sfx_c;
  logic                timer_load_c;
  logic [TIMER_W-1:0]  timer_val_c;
  logic                timer_done;

  note_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sfx       <= SFX_DIR;
      freq      <= NOTE_OFF;
      playing_o <= 1'b0;
    end else begin
      state     <= state_n;
      sfx       <= sfx_n;
      freq      <= freq_n;
      playing_o <= playing_n;
    end
  end

  // Arbitration, preemption and note sequencing; outputs follow the next state.
  always_comb begin
    state_n      = state;
    sfx_n        = sfx;
    timer_load_c = 1'b0;
    timer_val_c  = '0;
    ev_valid_c   = goodColl_i | badColl_i | (|direction_i);
    ev_sfx_c     = badColl_i ? SFX_BAD : (goodColl_i ? SFX_GOOD : SFX_DIR);

    if (mute_i) begin
      state_n = IDLE;
    end else if (ev_valid_c && (state == IDLE || ev_sfx_c >= sfx)) begin
      state_n      = NOTE1;
      sfx_n        = ev_sfx_c;
      timer_load_c = 1'b1;
      timer_val_c  = (ev_sfx_c == SFX_DIR) ? BLIP_LOAD : NOTE_LOAD;
    end else begin
      case (state)
        NOTE1: begin
          if (timer_done) begin
            if (sfx == SFX_DIR) begin
              state_n = IDLE;
            end else begin
              state_n      = NOTE2;
              timer_load_c = 1'b1;
              timer_val_c  = NOTE_LOAD;
            end
          end
        end
        NOTE2: begin
          if (timer_done) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    freq_n    = note_code(state_n, sfx_n);
    playing_n = (state_n != IDLE);
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Sequences the game's sound effects: accepts one-cycle event pulses from game logic (good collision, bad collision, direction change), arbitrates between them by fixed priority, and drives the 8-bit tone-divider code to the tone generator for a timed one- or two-note effect. It takes over the role of the purely combinational frequency lookup: it holds each note for a programmed duration and returns to silence. Sits between game-state logic and the square-wave tone generator in the 10 MHz domain.

## Interface
- NOTE_CYCLES, 1_000_000, length of each jingle note in clock cycles (100 ms at 10 MHz); must be ≥ 2
- BLIP_CYCLES, 250_000, length of the direction blip in clock cycles; must be ≥ 2 and ≤ NOTE_CYCLES
- clk  input  1  system clock, 10 MHz
- rst  input  1  reset, asynchronous, active-high
- goodColl_i  input  1  good-collision event pulse
- badColl_i  input  1  bad-collision event pulse
- direction_i  input  4  direction-change pulse; any bit set = event
- mute_i  input  1  level; high silences output and blocks new effects
- freq  output  8  tone-divider code, 0 = silent (registered)
- playing_o  output  1  high while an effect is sounding (registered)

## Operation
- Divider codes: A4 = 89, E5 = 59, D#4 = 126, G3 = 199, C4 = 149. Silence = 0.
- Effects:
  - BAD (badColl_i, priority 2): D#4 for NOTE_CYCLES, then G3 for NOTE_CYCLES.
  - GOOD (goodColl_i, priority 1): A4 for NOTE_CYCLES, then E5 for NOTE_CYCLES.
  - DIR (|direction_i, priority 0): C4 for BLIP_CYCLES, single note.
- Same-cycle events: the highest-priority event wins; the others are dropped, not queued.
- Preemption: a new event with priority ≥ the current effect's priority restarts from its first note with a full count. A lower-priority event during playback is dropped.
- FSM states:
  - IDLE: freq = 0, playing_o = 0. On an event (mute_i low), go to NOTE1.
  - NOTE1: plays the first note. When the timer expires, go to NOTE2 for BAD/GOOD, or to IDLE for DIR.
  - NOTE2: plays the second note. When the timer expires, go to IDLE.
- mute_i high:
  - From any state, go to IDLE on the next edge.
  - Events are ignored while mute_i is high.
  - After release, only events arriving after release start effects.
- Timer: down-counter of width $clog2(NOTE_CYCLES+1).
  - Loaded with duration−1 on note entry.
  - The note ends on the cycle the counter reads 0.
  - Each note therefore lasts exactly its duration in cycles.
- Reset (async, any time including mid-effect): state IDLE, freq = 0, playing_o = 0, counter = 0, current effect cleared.

## Timing
- Event sampled at edge k; freq and playing_o take the first-note values after edge k (one-cycle latency).
- Note transitions are back to back, with no silent gap between NOTE1 and NOTE2.
- Return to 0 after the final note's last cycle; playing_o falls on the same edge.
- Preemption takes effect on the edge that samples the event, using the same one-cycle latency.
- An event arriving in the final cycle of an effect is honored (same-priority restart, or a fresh start from IDLE).
- Outputs are glitch-free: both are register outputs, with no combinational path from the inputs.

## Structure
- Package sound_pkg holds:
  - The note divider localparams (NOTE_A4, NOTE_E5, NOTE_DS4, NOTE_G3, NOTE_C4, NOTE_OFF).
  - typedef enum logic [1:0] sfx_e {SFX_DIR, SFX_GOOD, SFX_BAD}, whose encoding equals priority.
  - typedef enum state_e {IDLE, NOTE1, NOTE2}.
- Sub-module note_timer, parameterized by width:
  - Inputs: load, load value, clk, rst.
  - Output: done.
- The sequencer holds the FSM, the arbiter and the note lookup.

## Test plan
- Reset mid-BAD-note → freq = 0 and playing_o = 0 immediately (asynchronous). After release, no sound until a new event arrives.
- GOOD pulse (NOTE_CYCLES = 8) → freq = 89 for 8 cycles, then 59 for 8 cycles, then 0. playing_o is high for exactly 16 cycles, starting one cycle after the pulse.
- goodColl_i, badColl_i and direction_i = 4'b0010 pulsed in the same cycle → BAD sequence: 126 then 199. No GOOD or DIR sound afterward.
- DIR playing (BLIP_CYCLES = 4), badColl_i pulsed in its 2nd cycle → freq = 126 the next cycle, with a full 8-cycle note. A direction pulse during the BAD effect → ignored.
- GOOD pulse during GOOD's NOTE2 → restart at 89 with a full count. GOOD pulse in the last cycle of NOTE2 → 89 follows with no intervening 0.
- mute_i raised during GOOD NOTE1 → 0 next cycle. Events while muted are ignored. After mute release, a DIR pulse → 149 for 4 cycles.
